// File: rtl/mont_exp_ctrl.sv
// -----------------------------------------------------------------------------
// mont_exp_ctrl
//
// Sequencer for modular exponentiation X^E mod M using left-to-right binary
// square-and-multiply. Drives one external Montgomery multiplier core through
// a start/done handshake: converts X into the Montgomery domain, runs the
// square/multiply loop over the exponent bits, then converts back.
//
// Optional feature macro: MONT_EXP_SKIP_ZEROS_EN
//   When defined, leading zero bits of the exponent are stepped over (one
//   cycle per bit, no core operation) before the first square.
//   When undefined, every one of the e_len bits is squared.
//
// Ports
//   clk          in   1       clock, rising edge
//   resetn       in   1       asynchronous active-low reset
//   start        in   1       request pulse, sampled only in IDLE
//   in_x         in   WIDTH   base X (< M)
//   in_e         in   E_BITS  exponent E
//   e_len        in   CNT_W   number of exponent bits used, LSB-aligned
//   in_m         in   WIDTH   odd modulus M
//   in_r         in   WIDTH   R mod M, R = 2^WIDTH
//   in_r2        in   WIDTH   R^2 mod M
//   mont_start   out  1       start pulse to the core
//   mont_a       out  WIDTH   core operand A, held for the whole operation
//   mont_b       out  WIDTH   core operand B, held for the whole operation
//   mont_m       out  WIDTH   modulus copy, updated only on accepted start
//   mont_result  in   WIDTH   core result
//   mont_done    in   1       core completion (level or pulse)
//   result       out  WIDTH   X^E mod M
//   done         out  1       pulse when result becomes valid
//   busy         out  1       run in progress
//
// State table
//   state     | meaning
//   S_IDLE    | waiting for start
//   S_TOMONT  | xt = MM(x, R^2 mod M)
//   S_SQR     | acc = MM(acc, acc); also hosts the leading-zero scan phase
//   S_MUL     | acc = MM(acc, xt)
//   S_FROMONT | result = MM(acc, 1)
//   S_FIN     | done pulse, back to idle
//
// Phases inside an operation state
//   PH_ISSUE  | one cycle with mont_start high
//   PH_WAIT   | guard window of two cycles, then wait for mont_done
//   PH_SCAN   | one cycle per leading zero exponent bit (skip-zeros build)
// -----------------------------------------------------------------------------
module mont_exp_ctrl #(
    parameter int WIDTH  = 1024,
    parameter int E_BITS = 1024,
    parameter int CNT_W  = 11
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [WIDTH-1:0]  in_x,
    input  logic [E_BITS-1:0] in_e,
    input  logic [CNT_W-1:0]  e_len,
    input  logic [WIDTH-1:0]  in_m,
    input  logic [WIDTH-1:0]  in_r,
    input  logic [WIDTH-1:0]  in_r2,
    output logic              mont_start,
    output logic [WIDTH-1:0]  mont_a,
    output logic [WIDTH-1:0]  mont_b,
    output logic [WIDTH-1:0]  mont_m,
    input  logic [WIDTH-1:0]  mont_result,
    input  logic              mont_done,
    output logic [WIDTH-1:0]  result,
    output logic              done,
    output logic              busy
);

    localparam int IDX_W = (E_BITS > 1) ? $clog2(E_BITS) : 1;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TOMONT  = 3'd1,
        S_SQR     = 3'd2,
        S_MUL     = 3'd3,
        S_FROMONT = 3'd4,
        S_FIN     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        PH_ISSUE = 2'd0,
        PH_WAIT  = 2'd1,
        PH_SCAN  = 2'd2
    } phase_t;

    state_t              r_state;
    phase_t              r_phase;
    logic [1:0]          r_guard;
    logic [E_BITS-1:0]   r_e;
    logic [CNT_W-1:0]    r_idx;
    logic                r_len_zero;
    logic [WIDTH-1:0]    r_xt;
    logic [WIDTH-1:0]    r_acc;
    logic                r_mont_start;
    logic [WIDTH-1:0]    r_mont_a;
    logic [WIDTH-1:0]    r_mont_b;
    logic [WIDTH-1:0]    r_mont_m;
    logic [WIDTH-1:0]    r_result;
    logic                r_done;
    logic                r_busy;

    logic [CNT_W-1:0]    w_len;
    logic                w_ebit;
    logic                w_idx_zero;
    logic                w_step;
    logic [WIDTH-1:0]    w_acc_new;
    state_t              w_go_state;
    phase_t              w_go_phase;
    logic [WIDTH-1:0]    w_go_a;
    logic [WIDTH-1:0]    w_go_b;
    logic                w_idx_dec;

    // e_len wider than the exponent register is clamped to its width.
    assign w_len      = (e_len > CNT_W'(E_BITS)) ? CNT_W'(E_BITS) : e_len;
    assign w_ebit     = r_e[r_idx[IDX_W-1:0]];
    assign w_idx_zero = (r_idx == '0);

    // An operation completes only after the two-cycle guard has expired, so a
    // done level left over from the previous operation cannot be taken.
    assign w_step = ((r_phase == PH_WAIT) && (r_guard == 2'd0) && mont_done) ||
                    (r_phase == PH_SCAN);

    // Accumulator value seen by the decision logic: a completing square or
    // multiply forwards the core result so the next operands are correct.
    assign w_acc_new = (((r_state == S_SQR) || (r_state == S_MUL)) && (r_phase == PH_WAIT))
                       ? mont_result : r_acc;

    // Next state/phase and next operands for the step that ends the current
    // operation (or the current scan cycle).
    always_comb begin
        w_go_state = r_state;
        w_go_phase = PH_ISSUE;
        w_go_a     = r_mont_a;
        w_go_b     = r_mont_b;
        w_idx_dec  = 1'b0;
        case (r_state)
            S_TOMONT: begin
                if (r_len_zero) begin
                    w_go_state = S_FROMONT;
                    w_go_a     = w_acc_new;
                    w_go_b     = ONE;
                end else begin
                    w_go_state = S_SQR;
`ifdef MONT_EXP_SKIP_ZEROS_EN
                    w_go_phase = PH_SCAN;
`else
                    w_go_a     = w_acc_new;
                    w_go_b     = w_acc_new;
`endif
                end
            end
            S_SQR: begin
                if (r_phase == PH_SCAN) begin
                    // Leading-zero scan: first set bit starts the real loop.
                    if (w_ebit) begin
                        w_go_state = S_SQR;
                        w_go_a     = w_acc_new;
                        w_go_b     = w_acc_new;
                    end else if (w_idx_zero) begin
                        w_go_state = S_FROMONT;
                        w_go_a     = w_acc_new;
                        w_go_b     = ONE;
                    end else begin
                        w_idx_dec  = 1'b1;
                        w_go_phase = PH_SCAN;
                    end
                end else if (w_ebit) begin
                    w_go_state = S_MUL;
                    w_go_a     = w_acc_new;
                    w_go_b     = r_xt;
                end else if (w_idx_zero) begin
                    w_go_state = S_FROMONT;
                    w_go_a     = w_acc_new;
                    w_go_b     = ONE;
                end else begin
                    w_idx_dec  = 1'b1;
                    w_go_state = S_SQR;
                    w_go_a     = w_acc_new;
                    w_go_b     = w_acc_new;
                end
            end
            S_MUL: begin
                if (w_idx_zero) begin
                    w_go_state = S_FROMONT;
                    w_go_a     = w_acc_new;
                    w_go_b     = ONE;
                end else begin
                    w_idx_dec  = 1'b1;
                    w_go_state = S_SQR;
                    w_go_a     = w_acc_new;
                    w_go_b     = w_acc_new;
                end
            end
            S_FROMONT: begin
                w_go_state = S_FIN;
            end
            default: begin
                w_go_state = r_state;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_phase      <= PH_ISSUE;
            r_guard      <= 2'd0;
            r_e          <= '0;
            r_idx        <= '0;
            r_len_zero   <= 1'b0;
            r_xt         <= '0;
            r_acc        <= '0;
            r_mont_start <= 1'b0;
            r_mont_a     <= '0;
            r_mont_b     <= '0;
            r_mont_m     <= '0;
            r_result     <= '0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_mont_start <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // The first operation, MM(x, R^2), is issued directly.
                        r_state      <= S_TOMONT;
                        r_phase      <= PH_ISSUE;
                        r_mont_start <= 1'b1;
                        r_mont_a     <= in_x;
                        r_mont_b     <= in_r2;
                        r_mont_m     <= in_m;
                        r_acc        <= in_r;
                        r_e          <= in_e;
                        r_len_zero   <= (w_len == '0);
                        r_idx        <= (w_len == '0) ? '0 : (w_len - CNT_W'(1));
                        r_busy       <= 1'b1;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    if (r_phase == PH_ISSUE) begin
                        r_phase <= PH_WAIT;
                        r_guard <= 2'd2;
                    end else if ((r_phase == PH_WAIT) && (r_guard != 2'd0)) begin
                        r_guard <= r_guard - 2'd1;
                    end else if (w_step) begin
                        if (r_state == S_TOMONT) begin
                            r_xt <= mont_result;
                        end
                        if (r_state == S_FROMONT) begin
                            r_result <= mont_result;
                        end
                        r_acc   <= w_acc_new;
                        r_state <= w_go_state;
                        r_phase <= w_go_phase;
                        if ((w_go_phase == PH_ISSUE) && (w_go_state != S_FIN)) begin
                            r_mont_start <= 1'b1;
                            r_mont_a     <= w_go_a;
                            r_mont_b     <= w_go_b;
                        end
                        if (w_idx_dec) begin
                            r_idx <= r_idx - CNT_W'(1);
                        end
                        if (w_go_state == S_FIN) begin
                            r_done <= 1'b1;
                            r_busy <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign mont_start = r_mont_start;
    assign mont_a     = r_mont_a;
    assign mont_b     = r_mont_b;
    assign mont_m     = r_mont_m;
    assign result     = r_result;
    assign done       = r_done;
    assign busy       = r_busy;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mont_exp_ctrl
//
// Directed bench for mont_exp_ctrl with a behavioural Montgomery core.
// The driver issues requests and pushes the hand-computed result plus the
// expected number of core operations into a queue; a monitor pops and checks
// whenever done pulses. The core model works on the low 64 bits only, since
// every modulus used here is tiny; it computes a*b*R^-1 mod M with R = 2^WIDTH.
// The core runs either with pulse done or with a level done that is left high
// from the previous operation and only drops two cycles after mont_start.
// -----------------------------------------------------------------------------
module tb_mont_exp_ctrl;

    localparam int WIDTH  = 1024;
    localparam int E_BITS = 1024;
    localparam int CNT_W  = 11;
    localparam int TMO    = 20000;

`ifdef MONT_EXP_SKIP_ZEROS_EN
    localparam int N_B     = 9;
    localparam int N_CLAMP = 6;
    localparam int N_EZ    = 2;
`else
    localparam int N_B     = 13;
    localparam int N_CLAMP = 1028;
    localparam int N_EZ    = 6;
`endif

    logic              clk;
    logic              resetn;
    logic              start;
    logic [WIDTH-1:0]  in_x;
    logic [E_BITS-1:0] in_e;
    logic [CNT_W-1:0]  e_len;
    logic [WIDTH-1:0]  in_m;
    logic [WIDTH-1:0]  in_r;
    logic [WIDTH-1:0]  in_r2;
    logic              mont_start;
    logic [WIDTH-1:0]  mont_a;
    logic [WIDTH-1:0]  mont_b;
    logic [WIDTH-1:0]  mont_m;
    logic [WIDTH-1:0]  mont_result;
    logic              mont_done;
    logic [WIDTH-1:0]  result;
    logic              done;
    logic              busy;

    mont_exp_ctrl #(.WIDTH(WIDTH), .E_BITS(E_BITS), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .in_x        (in_x),
        .in_e        (in_e),
        .e_len       (e_len),
        .in_m        (in_m),
        .in_r        (in_r),
        .in_r2       (in_r2),
        .mont_start  (mont_start),
        .mont_a      (mont_a),
        .mont_b      (mont_b),
        .mont_m      (mont_m),
        .mont_result (mont_result),
        .mont_done   (mont_done),
        .result      (result),
        .done        (done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] res;
        int               starts;
    } exp_t;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    int     sc_cnt   = 0;

    longint mod_m  = 13;
    longint r_mod  = 0;
    longint r2_mod = 0;
    longint rinv   = 1;

    bit     level_mode = 1'b0;
    int     core_lat   = 3;
    bit     pend;
    int     lat_cnt;
    int     stale_cnt;
    longint core_res;

    task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h (upper bits nonzero=%0b) expected 0x%0h",
                      nm, act[63:0], |act[WIDTH-1:64], exp[63:0]);
    endtask

    function automatic longint rmod(input longint m);
        longint r;
        r = 1;
        for (int i = 0; i < WIDTH; i++) r = (r * 2) % m;
        return r;
    endfunction

    task automatic set_mod(input longint m);
        mod_m  = m;
        r_mod  = rmod(m);
        r2_mod = (r_mod * r_mod) % m;
        for (longint k = 1; k < m; k++) if (((r_mod * k) % m) == 1) rinv = k;
    endtask

    function automatic longint mm(input longint a, input longint b);
        return (((a * b) % mod_m) * rinv) % mod_m;
    endfunction

    // Behavioural Montgomery core.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend        <= 1'b0;
            lat_cnt     <= 0;
            stale_cnt   <= 0;
            core_res    <= 0;
            mont_done   <= 1'b0;
            mont_result <= '0;
        end else if (mont_start) begin
            pend     <= 1'b1;
            lat_cnt  <= core_lat;
            core_res <= mm(longint'(mont_a[63:0]), longint'(mont_b[63:0]));
            if (level_mode) stale_cnt <= 2;
            else mont_done <= 1'b0;
        end else begin
            if (stale_cnt > 0) begin
                stale_cnt <= stale_cnt - 1;
                if (stale_cnt == 1) mont_done <= 1'b0;
            end
            if (pend) begin
                if (lat_cnt == 0 && stale_cnt == 0) begin
                    mont_done   <= 1'b1;
                    mont_result <= WIDTH'(core_res);
                    pend        <= 1'b0;
                end else if (lat_cnt > 0) begin
                    lat_cnt <= lat_cnt - 1;
                end
            end else if (!level_mode) begin
                mont_done <= 1'b0;
            end
        end
    end

    // Monitor: counts core operations per run and checks each done pulse.
    always @(negedge clk) begin
        if (!resetn) begin
            sc_cnt = 0;
        end else begin
            if (mont_start) sc_cnt++;
            if (done) begin
                chk("done_expected", WIDTH'(sb.size() != 0), WIDTH'(1));
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", result, e.res);
                    chk("mont_start_count", WIDTH'(sc_cnt), WIDTH'(e.starts));
                end
                sc_cnt = 0;
            end
        end
    end

    task automatic issue(input longint x, input longint e, input int elen, input longint m,
                         input longint exp_res, input int exp_starts);
        exp_t ent;
        set_mod(m);
        @(negedge clk);
        in_x  = '0;  in_x[63:0] = x;
        in_e  = '0;  in_e[63:0] = e;
        e_len = CNT_W'(elen);
        in_m  = WIDTH'(m);
        in_r  = WIDTH'(r_mod);
        in_r2 = WIDTH'(r2_mod);
        start = 1'b1;
        ent.res    = WIDTH'(exp_res);
        ent.starts = exp_starts;
        sb.push_back(ent);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", WIDTH'(busy), WIDTH'(1));
    endtask

    task automatic wait_done(input string nm);
        int t;
        t = 0;
        while (done !== 1'b1 && t < TMO) begin
            @(negedge clk);
            t++;
        end
        if (done !== 1'b1) begin
            n_checks++;
            $display("FAIL %s: no done after %0d cycles, required a done pulse", nm, t);
            sb.delete();
        end else begin
            @(negedge clk);
            chk({nm, "_done_width"}, WIDTH'(done), WIDTH'(0));
            chk({nm, "_busy_idle"}, WIDTH'(busy), WIDTH'(0));
        end
    endtask

    task automatic run(input string nm, input longint x, input longint e, input int elen,
                       input longint m, input longint exp_res, input int exp_starts);
        issue(x, e, elen, m, exp_res, exp_starts);
        wait_done(nm);
    endtask

    initial begin
        int seen;
        resetn = 1'b0;
        start  = 1'b0;
        in_x   = '0;
        in_e   = '0;
        e_len  = '0;
        in_m   = '0;
        in_r   = '0;
        in_r2  = '0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", WIDTH'({mont_start, done, busy}), WIDTH'(0));
        chk("rst_data", mont_a | mont_b | mont_m | result, WIDTH'(0));
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // 5^3 mod 13 = 125 - 117 = 8
        run("x5_e3", 5, 3, 2, 13, 8, 6);
        // 7^11 = 1977326743 = 101*19577492 + 51
        run("x7_e11", 7, 'h0B, 8, 101, 51, N_B);
        chk("mont_m_held", mont_m, WIDTH'(101));
        run("elen0", 9, 0, 0, 13, 1, 2);
        run("e1", 9, 1, 1, 13, 9, 4);
        // e_len above E_BITS is clamped to 1024 bits; leading zeros only square R
        run("clamp", 5, 3, 2047, 13, 8, N_CLAMP);

        // stale level done from the previous operation
        level_mode = 1'b1;
        core_lat   = 4;
        run("stale_x7", 7, 'h0B, 8, 101, 51, N_B);
        run("stale_x5", 5, 3, 2, 13, 8, 6);
        run("stale_ezero", 9, 0, 4, 13, 1, N_EZ);
        level_mode = 1'b0;
        core_lat   = 3;
        repeat (3) @(negedge clk);

        // start mid-run must be ignored
        issue(7, 'h0B, 8, 101, 51, N_B);
        repeat (20) @(negedge clk);
        in_x  = '0; in_x[63:0] = 5;
        in_e  = '0; in_e[63:0] = 3;
        e_len = CNT_W'(2);
        in_m  = WIDTH'(13);
        in_r  = WIDTH'(rmod(13));
        in_r2 = WIDTH'((rmod(13) * rmod(13)) % 13);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_held", WIDTH'(busy), WIDTH'(1));
        chk("mont_m_stable", mont_m, WIDTH'(101));
        wait_done("ignored_start");

        // reset during the first square
        issue(7, 'h0B, 8, 101, 51, N_B);
        seen = 0;
        for (int t = 0; t < 2000 && seen < 2; t++) begin
            @(negedge clk);
            if (mont_start) seen++;
        end
        chk("reached_sqr", WIDTH'(seen), WIDTH'(2));
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("midrst_ctrl", WIDTH'({mont_start, done, busy}), WIDTH'(0));
        chk("midrst_data", mont_a | mont_b | mont_m | result, WIDTH'(0));
        sb.delete();
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run("after_rst", 5, 3, 2, 13, 8, 6);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", WIDTH'(sb.size()), WIDTH'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
